// File: rtl/playback_sequencer_if.sv
// Button pulses into, and playback status out of, the beat scheduler.
interface playback_sequencer_if;
   logic        play_1p;
   logic        stop_1p;
   logic        speedup_1p;
   logic        speeddown_1p;
   logic [11:0] ibeat;
   logic        beat_en;
   logic        playing;
   logic        mute;
   logic [2:0]  speed;

   modport master (
      output play_1p, stop_1p, speedup_1p, speeddown_1p,
      input  ibeat, beat_en, playing, mute, speed
   );

   modport slave (
      input  play_1p, stop_1p, speedup_1p, speeddown_1p,
      output ibeat, beat_en, playing, mute, speed
   );
endinterface

// File: rtl/playback_sequencer.sv
// Play/pause/stop beat scheduler with 5-level speed divider.
// Define PLAYBACK_LOOP_EN to wrap the song instead of stopping in DONE.
module playback_sequencer #(
   parameter int LEN      = 64,
   parameter int BASE_DIV = 4194304
) (
   input  logic                 clk,
   input  logic                 rst,
   playback_sequencer_if.slave  bus
);
   localparam int DW = $clog2(BASE_DIV * 4);
   localparam int PW = DW + 1;
   localparam logic [PW-1:0] PMAX = PW'(BASE_DIV * 4);
   localparam logic [11:0]   LAST = 12'(LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [DW-1:0] div_q;
   logic [11:0]   ibeat_q;
   logic          beat_q;
   logic          play_q;
   logic          mute_q;
   logic [2:0]    speed_q;
   logic [2:0]    speed_d;
   logic          spd_chg;
   logic [PW-1:0] per;
   logic [DW-1:0] pm1;

   assign per = PMAX >> speed_q;
   assign pm1 = DW'(per - 1'b1);

   // Opposing presses cancel; saturated presses are no-ops.
   always_comb begin
      speed_d = speed_q;
      if (bus.speedup_1p && !bus.speeddown_1p
          && speed_q != 3'd4)
         speed_d = speed_q + 3'd1;
      else if (bus.speeddown_1p && !bus.speedup_1p
               && speed_q != 3'd0)
         speed_d = speed_q - 3'd1;
   end

   assign spd_chg = (speed_d != speed_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         ibeat_q <= '0;
         beat_q  <= 1'b0;
         play_q  <= 1'b0;
         mute_q  <= 1'b1;
         speed_q <= 3'd2;
      end else begin
         speed_q <= speed_d;
         beat_q  <= 1'b0;
         if (spd_chg)
            div_q <= '0;
         if (bus.stop_1p) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            ibeat_q <= '0;
            play_q  <= 1'b0;
            mute_q  <= 1'b1;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (bus.play_1p) begin
                     state_q <= S_PLAY;
                     play_q  <= 1'b1;
                     mute_q  <= 1'b0;
                  end
               end
               S_PLAY: begin
                  if (bus.play_1p) begin
                     state_q <= S_PAUSE;
                     play_q  <= 1'b0;
                     mute_q  <= 1'b1;
                  end else if (!spd_chg) begin
                     if (div_q != pm1) begin
                        div_q <= div_q + 1'b1;
                     end else begin
                        div_q <= '0;
`ifdef PLAYBACK_LOOP_EN
                        beat_q  <= 1'b1;
                        ibeat_q <= (ibeat_q == LAST) ?
                                   12'd0 : ibeat_q + 12'd1;
`else
                        if (ibeat_q == LAST) begin
                           state_q <= S_DONE;
                           play_q  <= 1'b0;
                           mute_q  <= 1'b1;
                        end else begin
                           beat_q  <= 1'b1;
                           ibeat_q <= ibeat_q + 12'd1;
                        end
`endif
                     end
                  end
               end
               S_PAUSE: begin
                  if (bus.play_1p) begin
                     state_q <= S_PLAY;
                     play_q  <= 1'b1;
                     mute_q  <= 1'b0;
                  end
               end
               S_DONE: begin
                  if (bus.play_1p) begin
                     state_q <= S_PLAY;
                     ibeat_q <= '0;
                     div_q   <= '0;
                     play_q  <= 1'b1;
                     mute_q  <= 1'b0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.ibeat   = ibeat_q;
   assign bus.beat_en = beat_q;
   assign bus.playing = play_q;
   assign bus.mute    = mute_q;
   assign bus.speed   = speed_q;
endmodule

// File: tb/tb_playback_sequencer.sv
// Scoreboard bench for playback_sequencer against a cycle-level
// model of elapsed-cycles-per-beat playback.
module tb_playback_sequencer;
   localparam int LEN  = 8;
   localparam int BASE = 4;

   typedef struct packed {
      logic [11:0] ibeat;
      logic        beat_en;
      logic        playing;
      logic        mute;
      logic [2:0]  speed;
   } obs_t;

   typedef enum int { M_IDLE, M_PLAY, M_PAUSE, M_DONE } mode_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   playback_sequencer_if bus ();

   playback_sequencer #(
      .LEN      (LEN),
      .BASE_DIV (BASE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   obs_t  expq[$];
   int    n_chk  = 0;
   int    n_pass = 0;
   int    n_cyc  = 0;

   mode_t m_mode  = M_IDLE;
   int    m_elap  = 0;
   int    m_idx   = 0;
   int    m_speed = 2;
   bit    m_pulse = 0;

   function automatic int period(int s);
      return (BASE * 4) / (1 << s);
   endfunction

   task automatic model_step(bit r, bit p, bit s,
                             bit u, bit d);
      int ns;
      bit chg;
      m_pulse = 0;
      if (!r) begin
         m_mode  = M_IDLE;
         m_elap  = 0;
         m_idx   = 0;
         m_speed = 2;
         return;
      end
      ns = m_speed;
      if (u && !d) ns = (m_speed < 4) ? m_speed + 1 : 4;
      if (d && !u) ns = (m_speed > 0) ? m_speed - 1 : 0;
      chg = (ns != m_speed);
      if (s) begin
         m_mode = M_IDLE;
         m_elap = 0;
         m_idx  = 0;
      end else if (p) begin
         case (m_mode)
            M_IDLE:  m_mode = M_PLAY;
            M_PLAY:  m_mode = M_PAUSE;
            M_PAUSE: m_mode = M_PLAY;
            default: begin
               m_mode = M_PLAY;
               m_idx  = 0;
               m_elap = 0;
            end
         endcase
         if (chg) m_elap = 0;
      end else if (chg) begin
         m_elap = 0;
      end else if (m_mode == M_PLAY) begin
         m_elap++;
         if (m_elap == period(m_speed)) begin
            m_elap = 0;
            if (m_idx == LEN - 1) begin
`ifdef PLAYBACK_LOOP_EN
               m_idx   = 0;
               m_pulse = 1;
`else
               m_mode = M_DONE;
`endif
            end else begin
               m_idx++;
               m_pulse = 1;
            end
         end
      end
      m_speed = ns;
   endtask

   task automatic cyc(bit p = 0, bit s = 0, bit u = 0,
                      bit d = 0, bit r = 1);
      obs_t e;
      @(posedge clk);
      #2;
      rst              = r;
      bus.play_1p      = p;
      bus.stop_1p      = s;
      bus.speedup_1p   = u;
      bus.speeddown_1p = d;
      model_step(r, p, s, u, d);
      e.ibeat   = 12'(m_idx);
      e.beat_en = m_pulse;
      e.playing = (m_mode == M_PLAY);
      e.mute    = (m_mode != M_PLAY);
      e.speed   = 3'(m_speed);
      expq.push_back(e);
   endtask

   task automatic idle_n(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Monitor: every cycle the DUT presents a full status word.
   initial begin
      obs_t g, e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            g.ibeat   = bus.ibeat;
            g.beat_en = bus.beat_en;
            g.playing = bus.playing;
            g.mute    = bus.mute;
            g.speed   = bus.speed;
            n_chk++;
            n_cyc++;
            if (g === e)
               n_pass++;
            else
               $display("FAIL status cyc%0d got ib=%0d be=%b pl=%b mu=%b sp=%0d exp ib=%0d be=%b pl=%b mu=%b sp=%0d",
                        n_cyc, g.ibeat, g.beat_en, g.playing,
                        g.mute, g.speed, e.ibeat, e.beat_en,
                        e.playing, e.mute, e.speed);
         end
      end
   end

   initial begin
      int guard;
      bus.play_1p      = 1'b0;
      bus.stop_1p      = 1'b0;
      bus.speedup_1p   = 1'b0;
      bus.speeddown_1p = 1'b0;
      // reset, then play through a few beats
      cyc(.r(0));
      cyc(.r(0));
      idle_n(3);
      cyc(.p(1));
      idle_n(13);
      // pause two cycles into a beat, resume after 20
      idle_n(1);
      cyc(.p(1));
      idle_n(20);
      cyc(.p(1));
      idle_n(6);
      // speed sweep up with saturation, then down
      cyc(.u(1));
      idle_n(2);
      cyc(.u(1));
      idle_n(2);
      cyc(.u(1));
      idle_n(4);
      for (int i = 0; i < 5; i++) begin
         cyc(.d(1));
         idle_n(3);
      end
      idle_n(20);
      // play+stop together at ibeat 5
      cyc(.s(1));
      cyc(.u(1));
      cyc(.u(1));
      cyc(.p(1));
      guard = 0;
      while (m_idx != 5 && guard < 100) begin
         cyc();
         guard++;
      end
      cyc(.p(1), .s(1));
      idle_n(2);
      // opposing speed presses in play mid-beat
      cyc(.d(1));
      cyc(.p(1));
      idle_n(2);
      cyc(.u(1), .d(1));
      idle_n(5);
      // run to the end of the song, then restart
      idle_n(60);
      cyc(.p(1));
      idle_n(10);
      // reset mid-play at ibeat 3, speed 4
      cyc(.s(1));
      cyc(.u(1));
      cyc(.u(1));
      cyc(.u(1));
      cyc(.p(1));
      guard = 0;
      while (m_idx != 3 && guard < 100) begin
         cyc();
         guard++;
      end
      cyc(.r(0), .p(1), .u(1));
      idle_n(3);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(.p($urandom_range(11) == 0),
             .s($urandom_range(79) == 0),
             .u($urandom_range(24) == 0),
             .d($urandom_range(24) == 0),
             .r($urandom_range(599) != 0));
      end
      idle_n(2);
      guard = 0;
      while (expq.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #3;
      if (expq.size() > 0) begin
         n_chk++;
         $display("FAIL drain left=%0d exp=0", expq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
